// File: rtl/apb_adder_master.sv
// -----------------------------------------------------------------------------
// apb_adder_master
//
// APB requester for the downstream adder slave. A start pulse accepted in IDLE
// latches two operands and runs three back-to-back APB transfers:
//   A: write operand A (f=01, addr BASE_ADDR)
//   B: write operand B (f=10, addr BASE_ADDR+1)
//   C: read the sum    (f=11, addr BASE_ADDR+2), PRDATA1 captured into result
// If PREADY stays low for TIMEOUT ACCESS cycles, the op aborts: the bus goes
// idle, err is set, done pulses and result is left unchanged.
//
// Handshake: an APB transfer completes on a rising edge where
// PSEL=1, PENABLE=1 and PREADY=1. PREADY is ignored in every other state.
//
// Ports:
//   PCLK, PRESET       clock, synchronous active-high reset
//   start              one-cycle request, sampled only in IDLE
//   op_a, op_b         operands, latched on an accepted start
//   PRDATA1, PREADY    slave read data and ready
//   PSEL, PENABLE,     APB control
//   PWRITE, PRWADDR,
//   PRWDATA, f         APB address/data and slave function select
//   result             captured sum, held until the next successful op
//   done               one-cycle pulse at the end of every op
//   busy               high in every non-IDLE state
//   err                sticky timeout flag, cleared by the next accepted start
// -----------------------------------------------------------------------------
module apb_adder_master #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          TIMEOUT   = 16
) (
   input  logic        PCLK,
   input  logic        PRESET,
   input  logic        start,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic [31:0] PRDATA1,
   input  logic        PREADY,
   output logic        PSEL,
   output logic        PENABLE,
   output logic        PWRITE,
   output logic [31:0] PRWADDR,
   output logic [31:0] PRWDATA,
   output logic [1:0]  f,
   output logic [31:0] result,
   output logic        done,
   output logic        busy,
   output logic        err
);

   // The wait counter only needs to reach TIMEOUT-1.
   localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {
      IDLE,
      SETUP_A,
      ACCESS_A,
      SETUP_B,
      ACCESS_B,
      SETUP_C,
      ACCESS_C
   } state_t;

   state_t          state_q, state_d;
   logic [31:0]     a_q, a_d;
   logic [31:0]     b_q, b_d;
   logic [WW-1:0]   wait_q, wait_d;
   logic [31:0]     result_q, result_d;
   logic            err_q, err_d;
   logic            done_q, done_d;
   logic            busy_q, busy_d;
   logic            psel_q, psel_d;
   logic            penable_q, penable_d;
   logic            pwrite_q, pwrite_d;
   logic [31:0]     addr_q, addr_d;
   logic [31:0]     wdata_q, wdata_d;
   logic [1:0]      f_q, f_d;

   logic            timed_out;

   assign timed_out = (wait_q == WW'(TIMEOUT - 1));

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      wait_d   = wait_q;
      result_d = result_q;
      err_d    = err_q;
      done_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = op_a;
               b_d     = op_b;
               err_d   = 1'b0;
               state_d = SETUP_A;
            end
         end
         SETUP_A: begin
            wait_d  = '0;
            state_d = ACCESS_A;
         end
         SETUP_B: begin
            wait_d  = '0;
            state_d = ACCESS_B;
         end
         SETUP_C: begin
            wait_d  = '0;
            state_d = ACCESS_C;
         end
         ACCESS_A, ACCESS_B, ACCESS_C: begin
            // PREADY is checked first so a ready on the timeout edge completes.
            if (PREADY) begin
               case (state_q)
                  ACCESS_A: state_d = SETUP_B;
                  ACCESS_B: state_d = SETUP_C;
                  default: begin
                     result_d = PRDATA1;
                     done_d   = 1'b1;
                     state_d  = IDLE;
                  end
               endcase
            end else if (timed_out) begin
               err_d   = 1'b1;
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               wait_d = wait_q + WW'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // Bus outputs are decoded from the next state so they are registered
      // and line up with the state they belong to.
      psel_d    = (state_d != IDLE);
      busy_d    = (state_d != IDLE);
      penable_d = (state_d == ACCESS_A) || (state_d == ACCESS_B) ||
                  (state_d == ACCESS_C);
      pwrite_d  = 1'b0;
      addr_d    = '0;
      wdata_d   = '0;
      f_d       = 2'b00;
      case (state_d)
         SETUP_A, ACCESS_A: begin
            f_d      = 2'b01;
            pwrite_d = 1'b1;
            addr_d   = BASE_ADDR;
            wdata_d  = a_d;
         end
         SETUP_B, ACCESS_B: begin
            f_d      = 2'b10;
            pwrite_d = 1'b1;
            addr_d   = BASE_ADDR + 32'd1;
            wdata_d  = b_d;
         end
         SETUP_C, ACCESS_C: begin
            f_d      = 2'b11;
            addr_d   = BASE_ADDR + 32'd2;
         end
         default: ;
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q   <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
         wait_q    <= '0;
         result_q  <= '0;
         err_q     <= 1'b0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         f_q       <= 2'b00;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         wait_q    <= wait_d;
         result_q  <= result_d;
         err_q     <= err_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
         psel_q    <= psel_d;
         penable_q <= penable_d;
         pwrite_q  <= pwrite_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         f_q       <= f_d;
      end
   end

   assign PSEL    = psel_q;
   assign PENABLE = penable_q;
   assign PWRITE  = pwrite_q;
   assign PRWADDR = addr_q;
   assign PRWDATA = wdata_q;
   assign f       = f_q;
   assign result  = result_q;
   assign done    = done_q;
   assign busy    = busy_q;
   assign err     = err_q;

endmodule

// File: doc/apb_adder_master.md
Name: apb_adder_master

Overview:
APB requester that drives the adder slave directly downstream on the shared APB bus. On a start pulse it latches two 32-bit operands and runs three APB transfers: load operand A (f=01), load operand B (f=10), then compute/read the sum (f=11). It captures PRDATA1 as the result and signals completion. A wait-state timeout prevents lockup if PREADY never asserts.

Parameters:
BASE_ADDR, 32'h0000_0000, PRWADDR for transfer A; B uses BASE_ADDR+1, C uses BASE_ADDR+2
TIMEOUT, 16, maximum ACCESS cycles spent waiting for PREADY before abort (>=2)

Ports:
PCLK  input  1  clock; all state updates on rising edge
PRESET  input  1  reset; synchronous, active-high
start  input  1  one-cycle request; sampled only in IDLE
op_a  input  32  operand A; latched on accepted start
op_b  input  32  operand B; latched on accepted start
PRDATA1  input  32  slave read data
PREADY  input  1  slave ready
PSEL  output  1  APB select
PENABLE  output  1  APB enable
PWRITE  output  1  1 for transfers A and B, 0 for transfer C
PRWADDR  output  32  APB address
PRWDATA  output  32  APB write data
f  output  2  slave function select
result  output  32  captured sum; holds until the next successful op
done  output  1  one-cycle pulse at end of an operation (success or abort)
busy  output  1  high in every non-IDLE state
err  output  1  sticky timeout flag; cleared on the next accepted start

Behaviour:
- Reset (synchronous, PRESET=1 at a rising edge) forces IDLE. PSEL, PENABLE, PWRITE, done, busy, and err are 0. PRWADDR, PRWDATA, result, and the latched operands are 0. f=00. Reset mid-transfer aborts with no done pulse.
- States: IDLE, SETUP_A, ACCESS_A, SETUP_B, ACCESS_B, SETUP_C, ACCESS_C. All outputs are registered.
- IDLE: PSEL=0, PENABLE=0, f=00. If start=1, latch op_a/op_b, clear err, and go to SETUP_A. start in any other state is ignored.
- SETUP_x: PSEL=1, PENABLE=0. Phase values are f, PWRITE, PRWADDR, and PRWDATA:
  - A: f=01, PWRITE=1, PRWADDR=BASE_ADDR, PRWDATA=a.
  - B: f=10, PWRITE=1, PRWADDR=BASE_ADDR+1, PRWDATA=b.
  - C: f=11, PWRITE=0, PRWADDR=BASE_ADDR+2, PRWDATA=0.
- SETUP_x always lasts exactly one cycle, then goes to ACCESS_x.
- ACCESS_x: PSEL=1, PENABLE=1. f, PWRITE, PRWADDR, and PRWDATA stay identical to SETUP_x, stable for the whole phase.
- In ACCESS_x, PREADY is sampled each rising edge. PREADY=0 stays in ACCESS_x and increments the wait counter. PREADY=1 completes the transfer:
  - A goes to SETUP_B.
  - B goes to SETUP_C.
  - C captures PRDATA1 into result, returns to IDLE, and pulses done.
- Transfers are back-to-back; there is no idle cycle between them.
- The slave registers PREADY one edge after it sees PENABLE=1. Nominal transfer is therefore 3 cycles (SETUP + 2 ACCESS), and a full op is 9 cycles.
- Latency: with start accepted at edge 0, done=1 during cycle 10 and result is valid from cycle 10. busy=1 for cycles 1..9.
- Timeout: the wait counter resets on entry to each ACCESS_x. If it reaches TIMEOUT with PREADY still 0:
  - go to IDLE and drop PSEL/PENABLE;
  - set err=1 and pulse done;
  - leave result unchanged.
- PREADY=1 and the timeout edge in the same cycle: PREADY wins, and the transfer completes normally.
- PREADY or PRDATA1 activity outside ACCESS_x is ignored.
- Arithmetic: this block performs none. result = PRDATA1 exactly, and the slave's 32-bit sum wraps modulo 2^32.

Test Plan:
- Basic add: reset, then start with a=5, b=7 against the slave. Expect A, B, C phases each 3 cycles with f 01/10/11, done at cycle 10, result=12, err=0.
- Wrap-around: a=32'hFFFF_FFFF, b=2 -> result=32'h0000_0001, done pulse, err=0.
- Wait states: a model slave delays PREADY by 4 extra cycles in ACCESS_B. Expect PSEL/PENABLE/f/PRWDATA stable throughout, completion 4 cycles later (done at cycle 14), result correct.
- Timeout: the model holds PREADY=0 in ACCESS_A. Expect the abort after 16 ACCESS cycles, bus returns to idle, err=1, done pulse, result unchanged from the prior op. A following start clears err and succeeds.
- Start ignored while busy: assert start with a=100 at cycle 4. Expect the operation to finish with the original operands and no second operation to begin.
- Reset mid-op: assert PRESET at cycle 5 (ACCESS_B). Expect all outputs at reset values at the next edge with no done pulse. A following start with a=1, b=1 -> result=2.
